// File: rtl/seq_alu_pkg.sv
// Shared types and the single-cycle arithmetic/logic evaluator for seq_alu.
package seq_alu_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] hi;
    logic             carry;
    logic             borrow;
    logic             ovf;
    logic             zero;
    logic             dz;
  } alu_out_t;

  // Operands arrive zero-extended to MAX_W; w selects the live width so one
  // function serves any instance width up to MAX_W.
  function automatic alu_out_t alu_single(input op_e op, input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b, input int unsigned w);
    alu_out_t         o;
    logic [MAX_W:0]   wide;
    logic [MAX_W-1:0] mask;
    logic             sa, sb, sr;
    o    = '0;
    wide = '0;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    sa   = 1'(a >> (w - 1));
    sb   = 1'(b >> (w - 1));
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        o.res   = wide[MAX_W-1:0] & mask;
        o.carry = 1'(wide >> w);
      end
      OP_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        o.res    = wide[MAX_W-1:0] & mask;
        o.borrow = (a < b);
      end
      OP_DIV: begin
        o.res = mask;
        o.hi  = a;
        o.dz  = 1'b1;
      end
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_XOR:  o.res = a ^ b;
      OP_NOT:  o.res = ~a & mask;
      default: o.res = '0;
    endcase
    sr = 1'(o.res >> (w - 1));
    if (op == OP_ADD) o.ovf = (sa == sb) && (sr != sa);
    if (op == OP_SUB) o.ovf = (sa != sb) && (sr != sa);
    o.zero = (o.res == '0);
    return o;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between issuing controller and seq_alu.
interface seq_alu_if #(parameter int unsigned W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         carry;
  logic         borrow;
  logic         ovf;
  logic         zero;
  logic         dz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, hi, carry, borrow, ovf, zero, dz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, hi, carry, borrow, ovf, zero, dz
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unit: shift-add multiply / restoring divide over one shared W-bit datapath.
module seq_alu_muldiv #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int unsigned CW = $clog2(W + 1);

  logic          busy;
  logic          div_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  shreg;
  logic [W-1:0]  opb;
  logic [W:0]    lhs;
  logic [W:0]    sum;
  logic [W:0]    prod;
  logic          take;

  // hi/lo present the post-iteration values so the top can capture the final
  // iteration on the same edge that completes it.
  always_comb begin
    lhs  = div_r ? {acc, shreg[W-1]} : {1'b0, acc};
    sum  = div_r ? (lhs - {1'b0, opb}) : (lhs + {1'b0, opb});
    take = 1'b0;
    prod = '0;
    hi   = '0;
    lo   = '0;
    if (div_r) begin
      take = ~sum[W];
      hi   = take ? sum[W-1:0] : lhs[W-1:0];
      lo   = {shreg[W-2:0], take};
    end else begin
      take = shreg[0];
      prod = take ? sum : lhs;
      hi   = prod[W:1];
      lo   = {prod[0], shreg[W-1:1]};
    end
    done = busy && (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      div_r <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      shreg <= '0;
      opb   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_r <= is_div;
      cnt   <= '0;
      acc   <= '0;
      shreg <= a;
      opb   <= b;
    end else if (busy) begin
      acc   <= hi;
      shreg <= lo;
      cnt   <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Handshaked W-bit ALU: single-cycle ops evaluated at accept, MUL/DIV via seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  state_e       state, state_nxt;
  op_e          op_in;
  logic         accept;
  logic         iter_start;
  logic         op_is_div;
  logic         is_div_r;
  logic         md_done;
  logic [W-1:0] md_hi, md_lo;
  alu_out_t     f;
  logic         unused_bits;

  logic [W-1:0] result_r, hi_r;
  logic         carry_r, borrow_r, ovf_r, zero_r, dz_r;

  assign op_in      = op_e'(bus.op);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign accept     = bus.in_valid && bus.in_ready;
  assign op_is_div  = (op_in == OP_DIV);
  assign iter_start = accept && ((op_in == OP_MUL) || (op_is_div && (bus.b != '0)));
  assign f          = alu_single(op_in, MAX_W'(bus.a), MAX_W'(bus.b), W);
  assign unused_bits = ^{f.res >> W, f.hi >> W};

  assign bus.result = result_r;
  assign bus.hi     = hi_r;
  assign bus.carry  = carry_r;
  assign bus.borrow = borrow_r;
  assign bus.ovf    = ovf_r;
  assign bus.zero   = zero_r;
  assign bus.dz     = dz_r;

  seq_alu_muldiv #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .is_div (op_is_div),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = iter_start ? BUSY : DONE;
      BUSY:    if (md_done) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      is_div_r <= 1'b0;
      result_r <= '0;
      hi_r     <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) is_div_r <= op_is_div;
      if (accept && !iter_start) begin
        result_r <= W'(f.res);
        hi_r     <= W'(f.hi);
        carry_r  <= f.carry;
        borrow_r <= f.borrow;
        ovf_r    <= f.ovf;
        zero_r   <= f.zero;
        dz_r     <= f.dz;
      end else if (state == BUSY && md_done) begin
        result_r <= md_lo;
        hi_r     <= md_hi;
        carry_r  <= 1'b0;
        borrow_r <= 1'b0;
        ovf_r    <= 1'b0;
        zero_r   <= is_div_r ? (md_lo == '0) : ({md_hi, md_lo} == '0);
        dz_r     <= 1'b0;
      end
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised W-bit ALU with a valid/ready handshake on both input and output.
- ADD, SUB and the logic ops complete in one cycle.
- MUL (shift-add) and DIV (restoring) are iterative and take W cycles.
- Produces a double-width result (hi/lo) and status flags.
- Sits between an operand-issuing controller and a result consumer that may apply backpressure. One operation is in flight at a time.

Parameters:
W, 8, operand and result-half width in bits (W >= 2).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept; equals (state==IDLE)
op  in  3  operation code (see Behaviour)
a  in  W  operand A (unsigned)
b  in  W  operand B (unsigned)
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  W  low result / quotient
hi  out  W  MUL high half / DIV remainder; 0 for other ops
carry  out  1  ADD carry-out
borrow  out  1  SUB borrow (a<b)
ovf  out  1  signed overflow on ADD/SUB (two's-complement view)
zero  out  1  result==0 (MUL: full 2W product==0)
dz  out  1  divide by zero

Behaviour:
Op codes:
- 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT A.
- Flags not defined for an op are 0.

Transfers:
- Input transfer occurs on a clk edge with in_valid && in_ready.
- Output transfer occurs on a clk edge with out_valid && out_ready.

Reset (synchronous, rst sampled high at posedge):
- state=IDLE.
- result, hi, all flags, out_valid = 0.
- Internal iteration registers cleared.
- in_ready=1 from the first edge after rst deasserts.

State machine IDLE / BUSY / DONE:
- IDLE, accept of single-cycle op (ADD, SUB, logic, DIV with b==0): compute, register outputs, go DONE. out_valid rises at the accept edge (latency 1).
- IDLE, accept of MUL or DIV with b!=0: latch a, b, op; clear the count; go BUSY.
- BUSY: one iteration per cycle, count 0..W-1. On the edge completing iteration W-1, write outputs and go DONE. out_valid is high exactly W cycles after the accept edge.
- DONE: out_valid=1 and all outputs held stable. On an out_ready edge: out_valid=0, go IDLE.
- No bypass: a new op is accepted no earlier than the edge after the output transfer.

Operand handling:
- in_valid is ignored outside IDLE.
- Operands and op are sampled only at the accept edge; later input changes have no effect.

Arithmetic:
- ADD: {carry,result}=a+b. ovf=(a[W-1]==b[W-1])&&(result[W-1]!=a[W-1]).
- SUB: result=a-b mod 2^W. borrow=(a<b). ovf=(a[W-1]!=b[W-1])&&(result[W-1]!=a[W-1]).
- MUL: {hi,result}=a*b, exact 2W-bit product.
- DIV, b!=0: result=a/b, hi=a%b.
- DIV, b==0: result=all ones, hi=a, dz=1, latency 1.

Reset mid-operation:
- rst in BUSY or DONE aborts the op; the result is discarded and never presented.

Simultaneous events:
- rst has priority over everything.
- out_ready while not out_valid is ignored.

Decomposition:
Package seq_alu_pkg contains:
- op_e enum (3-bit, codes above).
- state_e enum {IDLE, BUSY, DONE}.
- Function computing the single-cycle ops and their flags.

Sub-module seq_alu_muldiv is the iterative unit:
- Inputs: start, is_div, a, b.
- Outputs: done pulse, hi, lo.
- One shared W-bit accumulator/shift datapath and a clog2(W+1)-bit counter.
- The top level owns the handshake FSM and output registers.

Test Plan:
1. W=8, ADD a=0xF0, b=0x20 -> result=0x10, carry=1, zero=0, ovf=0, out_valid 1 cycle after accept. ADD 0x80+0x80 -> result=0x00, carry=1, zero=1, ovf=1.
2. SUB a=0x05, b=0x07 -> result=0xFE, borrow=1, ovf=0. SUB 0x80-0x01 -> result=0x7F, ovf=1.
3. MUL 0xFF*0xFF -> hi=0xFE, result=0x01. out_valid exactly 8 cycles after accept; in_ready=0 throughout; in_valid pulses during BUSY ignored.
4. DIV 200/7 -> result=28, hi=4, latency 8. DIV 200/0 -> result=0xFF, hi=200, dz=1, latency 1.
5. Backpressure: hold out_ready=0 for 5 cycles after XOR 0xAA^0x0F -> result=0xA5 stable and in_ready=0. Raise out_ready -> out_valid drops next edge, in_ready=1, a back-to-back AND is accepted.
6. Assert rst for one cycle on the 3rd BUSY cycle of a MUL -> out_valid never rises for it, in_ready=1 after reset. A following ADD 3+4 returns 7 with correct flags.
